// File: rtl/four_bit_seq_divider_if.sv
// ---------------------------------------------------------------------------
// four_bit_seq_divider_if
//   Handshake and data bundle between a requester and the sequential divider.
//
//   Signals
//     start      requester -> divider  request pulse, accepted only when idle
//     dividend   requester -> divider  DVD_W-bit dividend, captured on accept
//     divisor    requester -> divider  DVS_W-bit divisor, captured on accept
//     busy       divider -> requester  high while iterating
//     done       divider -> requester  one-cycle result-valid pulse
//     dbz        divider -> requester  divide-by-zero flag, held with result
//     quotient   divider -> requester  DVD_W-bit quotient
//     remainder  divider -> requester  DVS_W-bit remainder
//
//   Modports
//     master  the requester side (drives start and operands)
//     slave   the divider side (drives status and results)
// ---------------------------------------------------------------------------
interface four_bit_seq_divider_if #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) ();

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  dbz,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output dbz,
    output quotient,
    output remainder
  );

endinterface

// File: rtl/four_bit_seq_divider.sv
// ---------------------------------------------------------------------------
// four_bit_seq_divider
//   Sequential restoring divider: DVD_W-bit dividend / DVS_W-bit divisor.
//   One quotient bit is produced per clock, MSB first, so a nonzero divide
//   takes DVD_W iterations followed by a single DONE cycle. A zero divisor
//   skips the iterations and reports dbz with an all-ones quotient.
//
//   Ports
//     clk   system clock, all state changes on the rising edge
//     clr   synchronous active-low clear; aborts any operation in flight
//     bus   slave side of four_bit_seq_divider_if
//             start/dividend/divisor in, busy/done/dbz/quotient/remainder out
//
//   Results (quotient, remainder, dbz) are held from DONE until the next
//   accepted start; quotient bits shift in during RUN and are only
//   meaningful once done has pulsed.
// ---------------------------------------------------------------------------
module four_bit_seq_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  four_bit_seq_divider_if.slave  bus
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t           state_q;
  logic [DVD_W-1:0] dvd_q;     // dividend, shifted left one bit per iteration
  logic [DVS_W-1:0] dvs_q;     // captured divisor
  // The restored partial remainder is always below the divisor, so it fits
  // in DVS_W bits; the extra bit only exists in the shifted value pr_shift_d.
  logic [DVS_W-1:0] pr_q;
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;     // iterations left minus one
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  // -------------------------------------------------------------------------
  // One restoring-division step, evaluated from the current registers
  // -------------------------------------------------------------------------
  logic [DVS_W:0]   pr_shift_d;
  logic             fits_d;
  logic [DVS_W-1:0] pr_d;
  logic [DVD_W-1:0] dvd_d;
  logic [DVD_W-1:0] quo_d;

  always_comb begin
    pr_shift_d = {pr_q, dvd_q[DVD_W-1]};
    fits_d     = (pr_shift_d >= {1'b0, dvs_q});
    // When the divisor fits, the difference is below the divisor, so the
    // top bit of the subtraction is always zero and can be dropped.
    if (fits_d) begin
      pr_d = DVS_W'(pr_shift_d - {1'b0, dvs_q});
    end else begin
      pr_d = pr_shift_d[DVS_W-1:0];
    end
    dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
    quo_d = {quo_q[DVD_W-2:0], fits_d};
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless a branch below raises it.
      done_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            dvd_q <= bus.dividend;
            dvs_q <= bus.divisor;
            pr_q  <= '0;
            rem_q <= '0;
            cnt_q <= CNT_W'(DVD_W - 1);
            if (bus.divisor == '0) begin
              // Divide by zero: report immediately, no iterations.
              quo_q   <= '1;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              quo_q   <= '0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          dvd_q <= dvd_d;
          pr_q  <= pr_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            // Last iteration: publish the remainder together with done.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rem_q   <= pr_d;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          // start is ignored here; it is honoured only once back in IDLE.
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: doc/four_bit_seq_divider.md
Name: four_bit_seq_divider

Overview:
- Sequential restoring divider. It is the inverse operation of the 4-bit combinational multiplier.
- Takes an 8-bit dividend (e.g. a multiplier product) and a 4-bit divisor, and returns quotient and remainder after a fixed number of cycles.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the Multipliers area. Its outputs are intended to drive the 4-digit seven-segment display: divisor and quotient nibble on the left, remainder on the right.

Parameters:
- DVD_W, 8, dividend and quotient width in bits; also the number of iterations.
- DVS_W, 4, divisor and remainder width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; clr=0 resets.
- start  input  1  request pulse; accepted only in IDLE.
- dividend  input  DVD_W  dividend, captured when start is accepted.
- divisor  input  DVS_W  divisor, captured when start is accepted.
- busy  output  1  high while the RUN state is iterating.
- done  output  1  one-cycle pulse: result valid.
- dbz  output  1  divide-by-zero flag; valid with done, held with the result.
- quotient  output  DVD_W  quotient.
- remainder  output  DVS_W  remainder.

Behaviour:
- Reset (clr=0 at a rising edge): state=IDLE; busy=0, done=0, dbz=0, quotient=0, remainder=0; all internal registers cleared.
  - Reset has priority over every other event, including mid-RUN: the operation is aborted and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge → capture dividend and divisor. Partial remainder PR (DVS_W+1 bits) := 0. Iteration counter := DVD_W-1.
  - If the captured divisor=0 → go to DONE with quotient=all ones (0xFF), remainder=0, dbz=1.
  - Otherwise → go to RUN with dbz=0.
- RUN: one iteration per cycle, MSB first.
  - PR' = {PR[DVS_W-1:0], dividend_reg[MSB]}; shift dividend_reg left by 1.
  - If PR' >= divisor: PR := PR' - divisor and shift 1 into quotient LSB.
  - Else: PR := PR' and shift 0 into quotient LSB.
  - Counter decrements; the iteration at counter=0 transitions to DONE.
  - busy=1 in every RUN cycle.
- DONE: lasts exactly one cycle.
  - done=1, busy=0; remainder=PR[DVS_W-1:0]; then go to IDLE.
- Latency: with start sampled at edge 0 and divisor≠0, RUN iterations occur at edges 1..DVD_W and done is high for the cycle following edge DVD_W, i.e. done at cycle DVD_W+1 (9 for defaults).
- Divide-by-zero: done is high in the cycle immediately after the start edge.
- quotient, remainder and dbz:
  - Hold their values from DONE until the next accepted start.
  - On acceptance, quotient and remainder clear to 0 and dbz clears.
  - Intermediate quotient bits may be visible during RUN; they are valid only when done=1 or afterwards in IDLE.
- start while in RUN or DONE: ignored and not queued; dividend and divisor changes are ignored.
  - Back-to-back: start held high in IDLE right after DONE is accepted. Minimum issue interval is DVD_W+2 cycles.
- Invariant for divisor≠0: dividend = quotient*divisor + remainder, and remainder < divisor.
- No overflow is possible: quotient is DVD_W wide.

Test Plan:
- Reset, then dividend=0x4B, divisor=0x5, start 1 cycle → busy high 8 cycles; done pulse in cycle 9; quotient=0x0F, remainder=0x0, dbz=0.
- dividend=0x64, divisor=0x7 → quotient=0x0E, remainder=0x2. Then dividend=0xFF, divisor=0x1 → quotient=0xFF, remainder=0x0.
- dividend=0x03, divisor=0xF → quotient=0x00, remainder=0x3. Then dividend=0xE1, divisor=0xF → quotient=0x0F, remainder=0x0.
- Divide-by-zero: dividend=0x37, divisor=0x0 → done in the cycle after start, dbz=1, quotient=0xFF, remainder=0x0, busy never asserted.
- Start pulses and operand changes injected during RUN and in the DONE cycle → ignored; result is the original operation's.
  - Then start held high continuously → a new operation is accepted every 10 cycles.
- clr=0 at RUN iteration 4 → next cycle busy=0, done=0, all outputs 0, state IDLE; no done pulse follows.
  - A subsequent start with 0xC8/0x9 → quotient=0x16, remainder=0x2.
- Exhaustive randomized check over all 256×15 nonzero divisor pairs against the invariant.
